// File: rtl/video_pkg.sv
// Shared video types and framebuffer geometry used by the pixel fetch path.
package video_pkg;
  localparam int FB_W        = 320;
  localparam int FB_H        = 240;
  localparam int BPP         = 4;
  localparam int PAL_ENTRIES = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef logic [3:0] pal_idx_t;

  function automatic rgb444_t gray_entry(pal_idx_t i);
    rgb444_t c;
    c.r = i;
    c.g = i;
    c.b = i;
    return c;
  endfunction
endpackage

// File: rtl/palette_regfile.sv
// Double-buffered 16-entry palette: CPU writes land in the shadow bank, which is
// copied to the active bank once per frame; one combinational read port.
module palette_regfile
  import video_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     commit_i,
  input  logic     we_i,
  input  pal_idx_t wr_idx_i,
  input  rgb444_t  wr_data_i,
  input  pal_idx_t rd_idx_i,
  output rgb444_t  rd_data_o
);

  rgb444_t shadow_q [PAL_ENTRIES];
  rgb444_t active_q [PAL_ENTRIES];

  // The commit reads shadow_q before this cycle's write lands, so a
  // coincident write waits for the following frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        shadow_q[i] <= gray_entry(pal_idx_t'(i));
        active_q[i] <= gray_entry(pal_idx_t'(i));
      end
    end else begin
      if (we_i) shadow_q[wr_idx_i] <= wr_data_i;
      if (commit_i) begin
        for (int i = 0; i < PAL_ENTRIES; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

  assign rd_data_o = active_q[rd_idx_i];

endmodule

// File: rtl/pixel_fetch_pipeline.sv
// Three-stage pixel path: screen (x, y) -> VRAM word fetch -> nibble select ->
// palette lookup -> RGB, with hsync/vsync delayed to stay aligned with colour.
module pixel_fetch_pipeline
  import video_pkg::*;
#(
  parameter int VRAM_AW = 15
) (
  input  logic               sys_clock,
  input  logic               reset_n,
  input  logic               clock_25MHz_en,
  input  logic [9:0]         x,
  input  logic [8:0]         y,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               vsync_pulse,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_re,
  input  logic [15:0]        vram_rdata,
  input  logic               pal_we,
  input  logic [3:0]         pal_idx,
  input  logic [11:0]        pal_data,
  output logic [11:0]        rgb,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam logic [8:0] XH_MAX = 9'(FB_W - 1);
  localparam logic [7:0] YH_MAX = 8'(FB_H - 1);

  function automatic logic [8:0] sat_col(logic [9:0] xs);
    return (xs[9:1] > XH_MAX) ? XH_MAX : xs[9:1];
  endfunction

  function automatic logic [7:0] sat_row(logic [8:0] ys);
    return (ys[8:1] > YH_MAX) ? YH_MAX : ys[8:1];
  endfunction

  function automatic pal_idx_t nib_sel(logic [15:0] w, logic [1:0] s);
    return w[{s, 2'b00} +: 4];
  endfunction

  logic [8:0]         xh;
  logic [16:0]        yh_w;
  logic [16:0]        pix_d;
  logic [VRAM_AW-1:0] addr_p0_q;
  logic               vld_p0_q, hs_p0_q, vs_p0_q;
  logic [1:0]         sel_p0_q;
  logic               vld_p1_q, hs_p1_q, vs_p1_q;
  pal_idx_t           idx_p1_q;
  rgb444_t            pal_rd;
  rgb444_t            rgb_p2_d, rgb_p2_q;
  logic               hs_p2_q, vs_p2_q;

  // (y/2)*320 + x/2 built from two shifts so no multiplier is inferred
  assign xh    = sat_col(x);
  assign yh_w  = {9'b0, sat_row(y)};
  assign pix_d = (yh_w << 8) + (yh_w << 6) + {8'b0, xh};

  palette_regfile u_pal (
    .clk_i     (sys_clock),
    .rst_n_i   (reset_n),
    .commit_i  (vsync_pulse & clock_25MHz_en),
    .we_i      (pal_we),
    .wr_idx_i  (pal_idx),
    .wr_data_i (rgb444_t'(pal_data)),
    .rd_idx_i  (idx_p1_q),
    .rd_data_o (pal_rd)
  );

  always_comb begin
    rgb_p2_d = '0;
    if (vld_p1_q) rgb_p2_d = pal_rd;
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_p0_q <= '0;
      vld_p0_q  <= 1'b0;
      hs_p0_q   <= 1'b1;
      vs_p0_q   <= 1'b1;
      vld_p1_q  <= 1'b0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
      rgb_p2_q  <= '0;
      hs_p2_q   <= 1'b1;
      vs_p2_q   <= 1'b1;
    end else if (clock_25MHz_en) begin
      // stage A: issue the VRAM read
      addr_p0_q <= VRAM_AW'(pix_d[16:2]);
      vld_p0_q  <= video_on;
      hs_p0_q   <= hsync_in;
      vs_p0_q   <= vsync_in;
      // stage B: read data has been valid for several sys_clocks
      vld_p1_q  <= vld_p0_q;
      hs_p1_q   <= hs_p0_q;
      vs_p1_q   <= vs_p0_q;
      // stage C: palette lookup and blanking
      rgb_p2_q  <= rgb_p2_d;
      hs_p2_q   <= hs_p1_q;
      vs_p2_q   <= vs_p1_q;
    end
  end

  // Nibble select and index are qualified by the valid bits, so no reset
  always_ff @(posedge sys_clock) begin
    if (clock_25MHz_en) begin
      sel_p0_q <= pix_d[1:0];
      idx_p1_q <= nib_sel(vram_rdata, sel_p0_q);
    end
  end

  assign vram_addr = addr_p0_q;
  assign vram_re   = vld_p0_q;
  assign rgb       = rgb_p2_q;
  assign hsync_out = hs_p2_q;
  assign vsync_out = vs_p2_q;

endmodule

// File: tb/tb_pixel_fetch_pipeline.sv
// Directed bench for pixel_fetch_pipeline: addressing, latency/alignment,
// blanking, palette commit timing and mid-frame reset.
module tb_pixel_fetch_pipeline;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        von = 1'b0;
  logic        hs_i = 1'b1;
  logic        vs_i = 1'b1;
  logic        vp = 1'b0;
  logic [14:0] addr;
  logic        re;
  logic [15:0] rd = '0;
  logic        we = 1'b0;
  logic [3:0]  widx = '0;
  logic [11:0] wdata = '0;
  logic [11:0] rgb;
  logic        hs_o, vs_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pixel_fetch_pipeline dut (
    .sys_clock      (clk),
    .reset_n        (rst_n),
    .clock_25MHz_en (en),
    .x              (x),
    .y              (y),
    .video_on       (von),
    .hsync_in       (hs_i),
    .vsync_in       (vs_i),
    .vsync_pulse    (vp),
    .vram_addr      (addr),
    .vram_re        (re),
    .vram_rdata     (rd),
    .pal_we         (we),
    .pal_idx        (widx),
    .pal_data       (wdata),
    .rgb            (rgb),
    .hsync_out      (hs_o),
    .vsync_out      (vs_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int xx, input int yy, input logic v, input logic h,
                       input logic vv, input logic [15:0] d);
    x    = 10'(xx);
    y    = 9'(yy);
    von  = v;
    hs_i = h;
    vs_i = vv;
    rd   = d;
  endtask

  // One pixel period: four sys_clocks, enable high for the first edge only.
  task automatic tick();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Frame-start marker held for four sys_clocks; optional write on the enable edge.
  task automatic vpulse(input logic w, input logic [3:0] i, input logic [11:0] d);
    @(negedge clk);
    vp = 1'b1; en = 1'b1; we = w; widx = i; wdata = d;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);
    vp = 1'b0;
  endtask

  // Push one visible pixel at (0,0) whose fetched nibble 0 is idx, then check colour.
  task automatic render(input logic [3:0] idx, input string tag, input logic [11:0] exp);
    drive(0, 0, 1'b1, 1'b1, 1'b1, 16'h0000); tick();
    drive(0, 0, 1'b0, 1'b1, 1'b1, {12'h000, idx}); tick();
    drive(0, 0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();
    chk(tag, 32'(rgb), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rgb",  32'(rgb),  32'h000);
    chk("rst_hs",   32'(hs_o), 32'h1);
    chk("rst_vs",   32'(vs_o), 32'h1);
    chk("rst_re",   32'(re),   32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    rst_n = 1'b1;

    // Addressing and nibble selection
    drive(6, 3, 1'b1, 1'b1, 1'b1, 16'h0000); tick();
    chk("addr_6_3", 32'(addr), 32'd80);
    chk("re_6_3",   32'(re),   32'h1);
    drive(639, 479, 1'b1, 1'b1, 1'b1, 16'hA000); tick();
    chk("addr_639_479", 32'(addr), 32'd19199);
    chk("re_639_479",   32'(re),   32'h1);
    drive(0, 0, 1'b1, 1'b1, 1'b1, 16'h5000); tick();
    chk("rgb_6_3_sel3", 32'(rgb),  32'hAAA);
    chk("addr_0_0",     32'(addr), 32'd0);
    drive(2, 0, 1'b1, 1'b1, 1'b1, 16'h0007); tick();
    chk("rgb_639_sel3_gray5", 32'(rgb), 32'h555);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 16'h0030); tick();
    chk("rgb_sel0", 32'(rgb), 32'h777);
    chk("re_blank", 32'(re),  32'h0);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF); tick();
    chk("rgb_sel1", 32'(rgb), 32'h333);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF); tick();
    chk("rgb_blank_ffff", 32'(rgb), 32'h000);
    chk("re_blank_ffff",  32'(re),  32'h0);

    // Outputs hold while enable is low
    drive(100, 50, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("hold_addr", 32'(addr), 32'd0);
    chk("hold_re",   32'(re),   32'h0);
    chk("hold_hs",   32'(hs_o), 32'h1);

    // Line alignment: hsync low at steps 3..5, vsync low at 8..9, video from 6
    for (int j = 0; j < 12; j++) begin
      drive(j * 2, 0, (j >= 6), !(j >= 3 && j <= 5), !(j >= 8 && j <= 9), 16'h1111);
      tick();
      k = j - 2;
      chk("align_hs",  32'(hs_o), 32'(!(k >= 3 && k <= 5)));
      chk("align_vs",  32'(vs_o), 32'(!(k >= 8 && k <= 9)));
      chk("align_rgb", 32'(rgb),  (k >= 6) ? 32'h111 : 32'h000);
    end
    drive(0, 0, 1'b0, 1'b1, 1'b1, 16'h0000); tick(); tick();

    // Palette commit on the frame marker
    @(negedge clk); we = 1'b1; widx = 4'd5; wdata = 12'hF00;
    @(negedge clk); we = 1'b0;
    render(4'd5, "pal_pre_commit", 12'h555);
    vpulse(1'b0, 4'd0, 12'h000);
    render(4'd5, "pal_post_commit", 12'hF00);

    // Write coincident with commit is deferred one frame
    vpulse(1'b1, 4'd2, 12'h0F0);
    render(4'd2, "pal_wr_during_commit", 12'h222);
    vpulse(1'b0, 4'd0, 12'h000);
    render(4'd2, "pal_next_frame", 12'h0F0);

    // Mid-frame reset discards in-flight pixels and restores the grayscale palette
    drive(0, 0, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(0, 0, 1'b1, 1'b0, 1'b0, 16'h0009); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rgb", 32'(rgb),  32'h000);
    chk("midrst_hs",  32'(hs_o), 32'h1);
    chk("midrst_vs",  32'(vs_o), 32'h1);
    chk("midrst_re",  32'(re),   32'h0);
    @(negedge clk) rst_n = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();
    chk("flush_rgb", 32'(rgb),  32'h000);
    chk("flush_hs",  32'(hs_o), 32'h1);
    drive(0, 0, 1'b1, 1'b1, 1'b1, 16'h0000); tick();
    drive(0, 0, 1'b0, 1'b1, 1'b1, 16'h0005); tick();
    chk("postrst_lat2", 32'(rgb), 32'h000);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();
    chk("postrst_gray5", 32'(rgb), 32'h555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
